// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple sequencer: walks a register mask lowest index
// first and issues one memory access per set bit at consecutive addresses.
module lmsm_sequencer #(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 8,
    localparam int IDX_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [NREG-1:0]   reg_mask,
    input  logic [DATA_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [3:0]        xfer_count,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [IDX_W-1:0]  rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_wr_en,
    output logic [IDX_W-1:0]  rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WB,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic                store_reg, store_next;
    logic [NREG-1:0]     pending_reg, pending_next;
    logic [DATA_W-1:0]   addr_reg, addr_next;
    logic [3:0]          xfer_reg, xfer_next;
    logic [DATA_W-1:0]   wr_data_reg, wr_data_next;

    // Isolate the lowest set bit of the pending mask.
    logic [NREG-1:0]     lower_set;
    logic [NREG-1:0]     low_onehot;
    logic [NREG-1:0]     pending_clr;
    logic [IDX_W-1:0]    index;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_prio
            if (gi == 0) begin : g_first
                assign lower_set[gi] = 1'b0;
            end else begin : g_rest
                assign lower_set[gi] = lower_set[gi-1] | pending_reg[gi-1];
            end
            assign low_onehot[gi] = pending_reg[gi] & ~lower_set[gi];
        end
    endgenerate

    assign pending_clr = pending_reg & ~low_onehot;

    always_comb begin
        index = '0;
        for (int i = 0; i < NREG; i++) begin
            if (low_onehot[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    // Raw outputs before reset gating.
    logic              busy_c, done_c, mem_rd_c, mem_wr_c, rf_wr_en_c;
    logic [DATA_W-1:0] mem_addr_c, mem_wdata_c;
    logic [IDX_W-1:0]  rf_rd_addr_c, rf_wr_addr_c;

    always_comb begin
        state_next   = state_reg;
        store_next   = store_reg;
        pending_next = pending_reg;
        addr_next    = addr_reg;
        xfer_next    = xfer_reg;
        wr_data_next = wr_data_reg;
        busy_c       = 1'b0;
        done_c       = 1'b0;
        mem_rd_c     = 1'b0;
        mem_wr_c     = 1'b0;
        rf_wr_en_c   = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;
        rf_rd_addr_c = '0;
        rf_wr_addr_c = '0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    store_next   = is_store;
                    pending_next = reg_mask;
                    addr_next    = base_addr;
                    xfer_next    = '0;
                    state_next   = (reg_mask != '0) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                busy_c     = 1'b1;
                mem_addr_c = addr_reg;
                if (store_reg) begin
                    mem_wr_c     = 1'b1;
                    rf_rd_addr_c = index;
                    mem_wdata_c  = rf_rd_data;
                    if (mem_ack) begin
                        pending_next = pending_clr;
                        addr_next    = addr_reg + 1'b1;
                        xfer_next    = xfer_reg + 4'd1;
                        state_next   = (pending_clr != '0) ? S_REQ : S_DONE;
                    end
                end else begin
                    mem_rd_c = 1'b1;
                    if (mem_ack) begin
                        wr_data_next = mem_rdata;
                        state_next   = S_WB;
                    end
                end
            end
            S_WB: begin
                busy_c       = 1'b1;
                rf_wr_en_c   = 1'b1;
                rf_wr_addr_c = index;
                pending_next = pending_clr;
                addr_next    = addr_reg + 1'b1;
                xfer_next    = xfer_reg + 4'd1;
                state_next   = (pending_clr != '0) ? S_REQ : S_DONE;
            end
            S_DONE: begin
                busy_c     = 1'b1;
                done_c     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_rst) begin
            state_reg   <= S_IDLE;
            store_reg   <= 1'b0;
            pending_reg <= '0;
            addr_reg    <= '0;
            xfer_reg    <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            store_reg   <= store_next;
            pending_reg <= pending_next;
            addr_reg    <= addr_next;
            xfer_reg    <= xfer_next;
            wr_data_reg <= wr_data_next;
        end
    end

    // Reset forces every output low in the same cycle, so strobes drop before the edge.
    assign busy       = proc_rst ? 1'b0 : busy_c;
    assign done       = proc_rst ? 1'b0 : done_c;
    assign mem_rd     = proc_rst ? 1'b0 : mem_rd_c;
    assign mem_wr     = proc_rst ? 1'b0 : mem_wr_c;
    assign rf_wr_en   = proc_rst ? 1'b0 : rf_wr_en_c;
    assign mem_addr   = proc_rst ? '0   : mem_addr_c;
    assign mem_wdata  = proc_rst ? '0   : mem_wdata_c;
    assign rf_rd_addr = proc_rst ? '0   : rf_rd_addr_c;
    assign rf_wr_addr = proc_rst ? '0   : rf_wr_addr_c;
    assign xfer_count = proc_rst ? '0   : xfer_reg;
    assign rf_wr_data = proc_rst ? '0   : wr_data_reg;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: transaction-level reference model with a randomized
// memory responder, plus directed mask/base/latency/reset cases.
module tb_lmsm_sequencer;
    localparam int DATA_W = 16;
    localparam int NREG   = 8;

    logic              clk = 1'b0;
    always #5 clk = ~clk;

    logic              proc_rst, start, is_store;
    logic [NREG-1:0]   reg_mask;
    logic [DATA_W-1:0] base_addr;
    logic              busy, done;
    logic [3:0]        xfer_count;
    logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic              mem_rd, mem_wr, mem_ack;
    logic [2:0]        rf_rd_addr, rf_wr_addr;
    logic [DATA_W-1:0] rf_rd_data, rf_wr_data;
    logic              rf_wr_en;

    logic [DATA_W-1:0] rf [NREG];
    assign rf_rd_data = rf[rf_rd_addr];

    lmsm_sequencer #(.DATA_W(DATA_W), .NREG(NREG)) dut (
        .clk(clk), .proc_rst(proc_rst), .start(start), .is_store(is_store),
        .reg_mask(reg_mask), .base_addr(base_addr), .busy(busy), .done(done),
        .xfer_count(xfer_count), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_strobes"}, {mem_rd, mem_wr, rf_wr_en}, 0);
        chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_rfaddr"}, {rf_rd_addr, rf_wr_addr}, 0);
        chk({tag, "_xcnt"}, xfer_count, 0);
        chk({tag, "_rfwdata"}, rf_wr_data, 0);
    endtask

    typedef struct {
        int                r;
        logic [DATA_W-1:0] a;
    } xfer_t;

    // One LM/SM operation. dly = cycles the memory waits before acking;
    // repulse = pulse start again mid-operation; rst_at = cycle to assert reset (0 = none).
    task automatic run_op(input bit st, input logic [NREG-1:0] mask, input logic [DATA_W-1:0] base,
                          input int dly, input bit repulse, input int rst_at, input bit pat);
        xfer_t             q[$];
        int                n, c, wait_cnt, done_seen, popped, exp_done, k;
        bit                ld_pend, req;
        logic [DATA_W-1:0] ld_data;

        for (int i = 0; i < NREG; i++) rf[i] = pat ? DATA_W'(16'hA0 + i) : DATA_W'($urandom);
        k = 0;
        for (int i = 0; i < NREG; i++) begin
            if (mask[i]) begin
                q.push_back('{r: i, a: base + DATA_W'(k)});
                k++;
            end
        end
        n        = q.size();
        exp_done = (n == 0) ? 1 : (st ? n * (dly + 1) + 1 : n * (dly + 2) + 1);

        @(negedge clk);
        start = 1'b1; is_store = st; reg_mask = mask; base_addr = base; mem_ack = 1'b0;
        c = 0; wait_cnt = 0; done_seen = 0; popped = 0; ld_pend = 0; ld_data = '0;

        while (c < 200) begin
            @(negedge clk);
            c++;
            req = mem_rd | mem_wr;

            if (done_seen != 0) begin
                chk("idle_busy", busy, 0);
                chk("done_pulse", done, 0);
                chk("hold_xcnt", xfer_count, n);
                break;
            end

            if (req) begin
                chk("rd_wr_sel", {mem_rd, mem_wr}, st ? 2'b01 : 2'b10);
                if (q.size() == 0) chk("extra_req", req, 0);
                else begin
                    chk("mem_addr", mem_addr, q[0].a);
                    chk("xcnt_run", xfer_count, popped);
                    if (st) begin
                        chk("rf_rd_addr", rf_rd_addr, q[0].r);
                        chk("mem_wdata", mem_wdata, rf[q[0].r]);
                    end
                end
            end

            if (rf_wr_en) begin
                if (st || !ld_pend) chk("spurious_wr", rf_wr_en, 0);
                else begin
                    chk("rf_wr_addr", rf_wr_addr, q[0].r);
                    chk("rf_wr_data", rf_wr_data, ld_data);
                    void'(q.pop_front());
                    popped++;
                    ld_pend = 0;
                end
            end else if (ld_pend) begin
                chk("wr_missing", rf_wr_en, 1);
                ld_pend = 0;
            end

            if (done) begin
                done_seen++;
                chk("done_cycle", c, exp_done);
                chk("done_xcnt", xfer_count, n);
                chk("done_left", q.size(), 0);
                chk("done_busy", busy, 1);
            end else begin
                chk("busy_run", busy, 1);
            end

            if (rst_at != 0 && c == rst_at) begin
                mem_ack  = 1'b0;
                start    = 1'b0;
                proc_rst = 1'b1;
                #1;
                chk_zero("rst_now");
                @(negedge clk);
                chk_zero("rst_next");
                chk("rst_writes", popped, (rst_at - 1) / 2);
                proc_rst = 1'b0;
                @(negedge clk);
                chk("rst_idle", busy, 0);
                return;
            end

            start     = repulse && (c == 2);
            reg_mask  = NREG'($urandom);
            base_addr = DATA_W'($urandom);
            is_store  = 1'($urandom);
            if (req && q.size() > 0) begin
                if (wait_cnt == dly) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (st) begin
                        void'(q.pop_front());
                        popped++;
                        mem_rdata = DATA_W'($urandom);
                    end else begin
                        ld_data   = DATA_W'($urandom);
                        mem_rdata = ld_data;
                        ld_pend   = 1;
                    end
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = DATA_W'($urandom);
                    wait_cnt++;
                end
            end else begin
                // Stray acks outside a request must be ignored.
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = DATA_W'($urandom);
            end
        end
        start   = 1'b0;
        mem_ack = 1'b0;
        if (c >= 200) chk("timeout", done_seen, 1);
    endtask

    initial begin
        proc_rst = 1'b1; start = 1'b0; is_store = 1'b0; reg_mask = '0;
        base_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < NREG; i++) rf[i] = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        proc_rst = 1'b0;
        @(negedge clk);
        chk_zero("post_reset");

        run_op(1'b0, 8'h05, 16'h0040, 0, 1'b0, 0, 1'b0);
        run_op(1'b1, 8'hFF, 16'h1000, 0, 1'b0, 0, 1'b1);
        run_op(1'b1, 8'h80, 16'hFFFF, 3, 1'b0, 0, 1'b1);
        run_op(1'b0, 8'h03, 16'hFFFF, 0, 1'b0, 0, 1'b0);
        run_op(1'b0, 8'h00, 16'h1234, 0, 1'b0, 0, 1'b0);
        run_op(1'b1, 8'h00, 16'h4321, 0, 1'b1, 0, 1'b0);
        run_op(1'b0, 8'h0F, 16'h0200, 0, 1'b0, 3, 1'b0);
        run_op(1'b0, 8'h0F, 16'h0200, 0, 1'b0, 0, 1'b0);
        run_op(1'b1, 8'h36, 16'h0010, 1, 1'b1, 0, 1'b0);
        run_op(1'b0, 8'hA5, 16'h7FFE, 2, 1'b1, 0, 1'b0);
        repeat (40) begin
            run_op(1'($urandom), NREG'($urandom), DATA_W'($urandom),
                   $urandom_range(0, 3), 1'($urandom), 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
- Sequences the load-multiple / store-multiple (LM/SM) register transfers of the multicycle core, replacing the controller's counter-driven state loop.
- Walks an 8-bit register mask lowest index first and issues one memory access per set bit at consecutive addresses from a base.
- Drives register-file read/write ports and the memory port with a request/acknowledge handshake.
- Sits beside the main controller, which pulses start and waits for done.

Parameters:
- DATA_W, 16, data and address width.
- NREG, 8, register count; mask width is NREG, index width is 3.

Ports:
- clk, input, 1, clock; all state changes on rising edge.
- proc_rst, input, 1, reset (synchronous, active-high).
- start, input, 1, begin operation; sampled only in IDLE.
- is_store, input, 1, 1 = SM (RF to memory), 0 = LM (memory to RF); latched at start.
- reg_mask, input, NREG, register select, bit i = register i; latched at start.
- base_addr, input, DATA_W, first memory address; latched at start.
- busy, output, 1, high in every non-IDLE state.
- done, output, 1, one-cycle completion pulse.
- xfer_count, output, 4, completed transfers since the last start.
- mem_addr, output, DATA_W, memory address.
- mem_rd, output, 1, read request, held until acknowledged.
- mem_wr, output, 1, write request, held until acknowledged.
- mem_wdata, output, DATA_W, store data.
- mem_rdata, input, DATA_W, load data, valid with mem_ack.
- mem_ack, input, 1, access complete.
- rf_rd_addr, output, 3, RF read address (asynchronous RF read).
- rf_rd_data, input, DATA_W, RF read data.
- rf_wr_en, output, 1, RF write strobe.
- rf_wr_addr, output, 3, RF write address.
- rf_wr_data, output, DATA_W, RF write data.

Behaviour:
- States: IDLE, REQ, WB, DONE.
- Reset: state IDLE; pending mask, address, index, xfer_count, rf_wr_data all 0. Every output is 0 during and after reset.
- Reset mid-operation: returns to IDLE at the next edge and drops strobes immediately. No RF write or completion pulse occurs after reset is sampled.
- IDLE, start=1:
  - latch is_store, reg_mask into pending, base_addr into addr; clear xfer_count.
  - pending != 0: go to REQ. pending == 0: go to DONE with no memory or RF activity.
- start outside IDLE is ignored.
- Index: always the lowest set bit of pending, a combinational priority encode.
- REQ, load:
  - mem_rd=1, mem_addr=addr.
  - on mem_ack=1: capture mem_rdata into rf_wr_data and go to WB.
- WB (load only), one cycle:
  - rf_wr_en=1, rf_wr_addr=index.
  - clear the index bit in pending, addr+1, xfer_count+1.
  - then REQ if remaining pending != 0, else DONE.
- REQ, store:
  - mem_wr=1, mem_addr=addr, rf_rd_addr=index, mem_wdata=rf_rd_data (combinational pass-through).
  - on mem_ack=1: clear the bit, addr+1, xfer_count+1; then REQ if pending != 0, else DONE.
  - back-to-back stores keep mem_wr high continuously while address and data update.
- mem_ack outside REQ is ignored. Only one of mem_rd / mem_wr is ever high.
- DONE: done=1 for exactly one cycle, then IDLE. busy is high in REQ, WB and DONE.
- Address arithmetic: modulo 2^DATA_W; 16'hFFFF + 1 wraps to 16'h0000.
- Latency with single-cycle ack:
  - load: 2 cycles per register, plus 1 for DONE.
  - store: 1 cycle per register, plus 1 for DONE.
- Mask semantics:
  - full mask 8'hFF gives 8 transfers and xfer_count=8.
  - a mask change during busy has no effect.

Test Plan:
- LM, mask=8'b0000_0101, base=16'h0040, ack same cycle → mem_rd at 16'h0040 then 16'h0041; rf writes r0, then r2; done 5 cycles after start; xfer_count=2.
- SM, mask=8'hFF, base=16'h1000, RF holds ri=16'hA0+i → 8 consecutive mem_wr cycles with addresses 16'h1000..16'h1007 and data 16'hA0..16'hA7; done on cycle 9; xfer_count=8.
- SM, mask=8'h80, base=16'hFFFF, mem_ack delayed 3 cycles → mem_wr held 4 cycles at 16'hFFFF with r7 data; then done; internal addr wraps to 16'h0000.
- LM, mask=8'h00 → no mem_rd or rf_wr_en; done one cycle after start; xfer_count=0.
- LM, mask=8'h0F, proc_rst asserted in the second REQ → outputs all 0 next cycle; only r0 written; start after reset runs normally.
- start re-pulsed with a different mask while busy → ignored; the original transfer sequence completes unchanged.
